// File: rtl/rv2t_instruction_fetch_pkg.sv
// Shared widths, reset PC and FSM encoding for the rv2t instruction fetch stage.
package rv2t_instruction_fetch_pkg;

  localparam int unsigned IF_XLEN        = 32;
  localparam int unsigned IF_PC_BITWIDTH = 32;
  localparam logic [31:0] IF_START_PC    = 32'h0000_0000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/rv2t_instruction_fetch.sv
// Instruction fetch: issues one memory read per fetch request, tracks the PC,
// and handles redirects (start/jump) that arrive while a read is outstanding.
module rv2t_instruction_fetch
  import rv2t_instruction_fetch_pkg::*;
#(
  parameter int unsigned                XLEN        = IF_XLEN,
  parameter int unsigned                PC_BITWIDTH = IF_PC_BITWIDTH,
  parameter logic [PC_BITWIDTH-1:0]     START_PC    = PC_BITWIDTH'(IF_START_PC)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sync_reset,
  input  logic                   start,
  input  logic [PC_BITWIDTH-1:0] start_addr,
  input  logic                   fetch_enable,
  input  logic                   jump_enable,
  input  logic [PC_BITWIDTH-1:0] jump_addr,
  input  logic                   mem_read_ack,
  input  logic [XLEN-1:0]        mem_data,
  output logic                   mem_read_en,
  output logic [PC_BITWIDTH-1:0] mem_read_addr,
  output logic                   enable_out,
  output logic [XLEN-1:0]        IR_out,
  output logic [PC_BITWIDTH-1:0] PC_out,
  output logic                   busy,
  output logic                   exception_alignment
);

  fetch_state_t           state, state_n;
  logic [PC_BITWIDTH-1:0] pc, pc_n;
  logic                   pend_valid, pend_valid_n;
  logic [PC_BITWIDTH-1:0] pend_addr, pend_addr_n;
  logic                   mem_read_en_n;
  logic [PC_BITWIDTH-1:0] mem_read_addr_n;
  logic                   enable_out_n;
  logic [XLEN-1:0]        ir_n;
  logic [PC_BITWIDTH-1:0] pc_out_n;
  logic                   busy_n;
  logic                   exc_n;

  logic [PC_BITWIDTH-1:0] start_tgt;
  logic                   jump_sel;
  logic                   jump_ok;
  logic                   jump_bad;
  logic                   redirect_valid;
  logic [PC_BITWIDTH-1:0] redirect_addr;

  // Redirect decode: start outranks jump, start target is word-aligned by force.
  assign start_tgt      = start_addr & ~PC_BITWIDTH'(3);
  assign jump_sel       = jump_enable & ~start;
  assign jump_ok        = jump_sel & (jump_addr[1:0] == 2'b00);
  assign jump_bad       = jump_sel & (jump_addr[1:0] != 2'b00);
  assign redirect_valid = start | jump_ok;
  assign redirect_addr  = start ? start_tgt : jump_addr;

  // Next-state and next-output logic.
  always_comb begin
    state_n         = state;
    pc_n            = pc;
    pend_valid_n    = pend_valid;
    pend_addr_n     = pend_addr;
    mem_read_en_n   = 1'b0;
    mem_read_addr_n = mem_read_addr;
    enable_out_n    = 1'b0;
    ir_n            = IR_out;
    pc_out_n        = PC_out;
    exc_n           = jump_bad;

    if (sync_reset) begin
      state_n         = ST_IDLE;
      pc_n            = START_PC;
      pend_valid_n    = 1'b0;
      pend_addr_n     = '0;
      mem_read_addr_n = '0;
      ir_n            = '0;
      pc_out_n        = '0;
      exc_n           = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            pc_n = start_tgt;
          end else if (jump_ok) begin
            pc_n = jump_addr;
            if (fetch_enable) begin
              mem_read_en_n   = 1'b1;
              mem_read_addr_n = jump_addr;
              state_n         = ST_WAIT;
            end
          end else if (fetch_enable && !jump_bad) begin
            mem_read_en_n   = 1'b1;
            mem_read_addr_n = pc;
            state_n         = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (redirect_valid) begin
            pend_valid_n = 1'b1;
            pend_addr_n  = redirect_addr;
          end
          // A redirect seen this cycle overrides any older pending one.
          if (mem_read_ack) begin
            state_n      = ST_IDLE;
            pend_valid_n = 1'b0;
            if (redirect_valid) begin
              pc_n = redirect_addr;
            end else if (pend_valid) begin
              pc_n = pend_addr;
            end else begin
              ir_n         = mem_data;
              pc_out_n     = mem_read_addr;
              enable_out_n = 1'b1;
              pc_n         = pc + PC_BITWIDTH'(4);
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end

    busy_n = (state_n == ST_WAIT);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= ST_IDLE;
      pc                  <= START_PC;
      pend_valid          <= 1'b0;
      pend_addr           <= '0;
      mem_read_en         <= 1'b0;
      mem_read_addr       <= '0;
      enable_out          <= 1'b0;
      IR_out              <= '0;
      PC_out              <= '0;
      busy                <= 1'b0;
      exception_alignment <= 1'b0;
    end else begin
      state               <= state_n;
      pc                  <= pc_n;
      pend_valid          <= pend_valid_n;
      pend_addr           <= pend_addr_n;
      mem_read_en         <= mem_read_en_n;
      mem_read_addr       <= mem_read_addr_n;
      enable_out          <= enable_out_n;
      IR_out              <= ir_n;
      PC_out              <= pc_out_n;
      busy                <= busy_n;
      exception_alignment <= exc_n;
    end
  end

endmodule

// File: tb/tb_rv2t_instruction_fetch.sv
// Self-checking bench for rv2t_instruction_fetch: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_rv2t_instruction_fetch;

  localparam int unsigned XW = 32;
  localparam int unsigned PW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sync_reset;
  logic          start;
  logic [PW-1:0] start_addr;
  logic          fetch_enable;
  logic          jump_enable;
  logic [PW-1:0] jump_addr;
  logic          mem_read_ack;
  logic [XW-1:0] mem_data;
  logic          mem_read_en;
  logic [PW-1:0] mem_read_addr;
  logic          enable_out;
  logic [XW-1:0] IR_out;
  logic [PW-1:0] PC_out;
  logic          busy;
  logic          exception_alignment;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: architectural view (PC, one outstanding read, pending redirect).
  logic [PW-1:0] m_pc, m_addr, m_pcout, m_pend;
  logic [XW-1:0] m_ir;
  bit            m_outstanding, m_pendv, m_rd, m_en, m_exc;

  rv2t_instruction_fetch dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .sync_reset          (sync_reset),
    .start               (start),
    .start_addr          (start_addr),
    .fetch_enable        (fetch_enable),
    .jump_enable         (jump_enable),
    .jump_addr           (jump_addr),
    .mem_read_ack        (mem_read_ack),
    .mem_data            (mem_data),
    .mem_read_en         (mem_read_en),
    .mem_read_addr       (mem_read_addr),
    .enable_out          (enable_out),
    .IR_out              (IR_out),
    .PC_out              (PC_out),
    .busy                (busy),
    .exception_alignment (exception_alignment)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = '0; m_addr = '0; m_pcout = '0; m_pend = '0; m_ir = '0;
    m_outstanding = 0; m_pendv = 0; m_rd = 0; m_en = 0; m_exc = 0;
  endtask

  task automatic model_edge();
    bit            use_jump, good_jump, bad_jump, redir;
    logic [PW-1:0] target;
    m_rd = 0; m_en = 0; m_exc = 0;
    if (!reset_n || sync_reset) begin
      model_reset();
      return;
    end
    use_jump  = jump_enable && !start;
    good_jump = use_jump && (jump_addr % 4 == 0);
    bad_jump  = use_jump && (jump_addr % 4 != 0);
    redir     = start || good_jump;
    target    = start ? (start_addr / 4) * 4 : jump_addr;
    m_exc     = bad_jump;
    if (!m_outstanding) begin
      if (redir) m_pc = target;
      if (!start && !bad_jump && fetch_enable) begin
        m_rd = 1; m_addr = m_pc; m_outstanding = 1;
      end
    end else begin
      if (redir) begin m_pendv = 1; m_pend = target; end
      if (mem_read_ack) begin
        if (m_pendv) m_pc = m_pend;
        else begin
          m_ir = mem_data; m_pcout = m_addr; m_en = 1; m_pc = m_pc + 32'd4;
        end
        m_outstanding = 0; m_pendv = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    start = 0; fetch_enable = 0; jump_enable = 0; mem_read_ack = 0; sync_reset = 0;
  endtask

  function automatic logic [PW-1:0] rand_addr(input bit aligned);
    logic [PW-1:0] a;
    a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom());
    if (aligned) a[1:0] = 2'b00;
    return a;
  endfunction

  task automatic test_reset();
    reset_n = 0; sync_reset = 0; start = 0; start_addr = '0; fetch_enable = 0;
    jump_enable = 0; jump_addr = '0; mem_read_ack = 0; mem_data = '0;
    cycle(); cycle();
    vectors++;
    if ({mem_read_en, mem_read_addr, enable_out, IR_out, PC_out, busy, exception_alignment} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got en=%b addr=%h eo=%b ir=%h pc=%h busy=%b exc=%b, want all zero",
               mem_read_en, mem_read_addr, enable_out, IR_out, PC_out, busy, exception_alignment);
    end
    reset_n = 1;
    cycle();
  endtask

  task automatic test_basic_fetch();
    fetch_enable = 1; cycle();
    vectors++;
    if (mem_read_en !== 1'b1 || mem_read_addr !== 32'h0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_request: got en=%b addr=%h busy=%b, want 1 00000000 1", mem_read_en, mem_read_addr, busy);
    end
    cycle();
    vectors++;
    if (mem_read_en !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_pulse: got en=%b busy=%b, want 0 1", mem_read_en, busy);
    end
    mem_data = 32'h0000_0013; mem_read_ack = 1; cycle();
    vectors++;
    if (enable_out !== 1'b1 || IR_out !== 32'h13 || PC_out !== 32'h0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_deliver: got eo=%b ir=%h pc=%h busy=%b, want 1 00000013 00000000 0",
               enable_out, IR_out, PC_out, busy);
    end
    mem_data = 32'hDEAD_BEEF; cycle();
    vectors++;
    if (enable_out !== 1'b0 || IR_out !== 32'h13) begin
      miscompares++;
      $display("FAIL basic_hold: got eo=%b ir=%h, want 0 00000013", enable_out, IR_out);
    end
    fetch_enable = 1; cycle();
    vectors++;
    if (mem_read_addr !== 32'h4) begin
      miscompares++;
      $display("FAIL basic_pc_plus4: got addr=%h, want 00000004", mem_read_addr);
    end
    mem_read_ack = 1; cycle();
  endtask

  task automatic test_start_sequence();
    start = 1; start_addr = 32'h81; cycle();
    vectors++;
    if (mem_read_en !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_no_fetch: got en=%b busy=%b, want 0 0", mem_read_en, busy);
    end
    for (int k = 0; k < 3; k++) begin
      fetch_enable = 1; cycle();
      mem_data = 32'h1000 + 32'(k); mem_read_ack = 1; cycle();
      vectors++;
      if (enable_out !== 1'b1 || PC_out !== 32'h80 + 32'(4 * k) || IR_out !== 32'h1000 + 32'(k)) begin
        miscompares++;
        $display("FAIL start_seq%0d: got eo=%b pc=%h ir=%h, want 1 %h %h",
                 k, enable_out, PC_out, IR_out, 32'h80 + 32'(4 * k), 32'h1000 + 32'(k));
      end
    end
  endtask

  task automatic test_jump_fetch();
    jump_enable = 1; jump_addr = 32'h100; fetch_enable = 1; cycle();
    vectors++;
    if (mem_read_en !== 1'b1 || mem_read_addr !== 32'h100) begin
      miscompares++;
      $display("FAIL jump_fetch_req: got en=%b addr=%h, want 1 00000100", mem_read_en, mem_read_addr);
    end
    mem_data = 32'hAAAA_0001; mem_read_ack = 1; cycle();
    vectors++;
    if (enable_out !== 1'b1 || PC_out !== 32'h100) begin
      miscompares++;
      $display("FAIL jump_fetch_pc: got eo=%b pc=%h, want 1 00000100", enable_out, PC_out);
    end
    fetch_enable = 1; cycle();
    vectors++;
    if (mem_read_addr !== 32'h104) begin
      miscompares++;
      $display("FAIL jump_fetch_next: got addr=%h, want 00000104", mem_read_addr);
    end
    mem_read_ack = 1; cycle();
  endtask

  task automatic test_redirect_in_wait();
    fetch_enable = 1; cycle();
    jump_enable = 1; jump_addr = 32'h200; cycle();
    vectors++;
    if (mem_read_en !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_jump_hold: got en=%b busy=%b, want 0 1", mem_read_en, busy);
    end
    mem_data = 32'h5555_5555; mem_read_ack = 1; cycle();
    vectors++;
    if (enable_out !== 1'b0 || busy !== 1'b0 || PC_out !== 32'h104) begin
      miscompares++;
      $display("FAIL wait_jump_discard: got eo=%b busy=%b pc=%h, want 0 0 00000104", enable_out, busy, PC_out);
    end
    fetch_enable = 1; cycle();
    vectors++;
    if (mem_read_addr !== 32'h200) begin
      miscompares++;
      $display("FAIL wait_jump_target: got addr=%h, want 00000200", mem_read_addr);
    end
    jump_enable = 1; jump_addr = 32'h300; cycle();
    start = 1; start_addr = 32'h400; cycle();
    fetch_enable = 1; cycle();
    jump_enable = 1; jump_addr = 32'h500; mem_read_ack = 1; cycle();
    vectors++;
    if (enable_out !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL redirect_with_ack: got eo=%b busy=%b, want 0 0", enable_out, busy);
    end
    fetch_enable = 1; cycle();
    vectors++;
    if (mem_read_addr !== 32'h500) begin
      miscompares++;
      $display("FAIL last_redirect_wins: got addr=%h, want 00000500", mem_read_addr);
    end
    mem_read_ack = 1; cycle();
  endtask

  task automatic test_misaligned();
    start = 1; start_addr = 32'h600; cycle();
    jump_enable = 1; jump_addr = 32'h102; fetch_enable = 1; cycle();
    vectors++;
    if (exception_alignment !== 1'b1 || mem_read_en !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_flag: got exc=%b en=%b busy=%b, want 1 0 0", exception_alignment, mem_read_en, busy);
    end
    cycle();
    vectors++;
    if (exception_alignment !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_pulse: got exc=%b, want 0", exception_alignment);
    end
    fetch_enable = 1; cycle();
    vectors++;
    if (mem_read_addr !== 32'h600) begin
      miscompares++;
      $display("FAIL misalign_pc_kept: got addr=%h, want 00000600", mem_read_addr);
    end
    jump_enable = 1; jump_addr = 32'h703; cycle();
    vectors++;
    if (exception_alignment !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL misalign_in_wait: got exc=%b busy=%b, want 1 1", exception_alignment, busy);
    end
    mem_data = 32'h6666_0000; mem_read_ack = 1; cycle();
    vectors++;
    if (enable_out !== 1'b1 || PC_out !== 32'h600) begin
      miscompares++;
      $display("FAIL misalign_no_redirect: got eo=%b pc=%h, want 1 00000600", enable_out, PC_out);
    end
  endtask

  task automatic test_wrap_and_resets();
    start = 1; start_addr = 32'hFFFF_FFFC; cycle();
    fetch_enable = 1; cycle();
    mem_data = 32'h7777_7777; mem_read_ack = 1; cycle();
    vectors++;
    if (enable_out !== 1'b1 || PC_out !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL wrap_deliver: got eo=%b pc=%h, want 1 fffffffc", enable_out, PC_out);
    end
    fetch_enable = 1; cycle();
    vectors++;
    if (mem_read_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_pc: got addr=%h, want 00000000", mem_read_addr);
    end
    sync_reset = 1; mem_read_ack = 0; cycle();
    vectors++;
    if ({mem_read_en, mem_read_addr, enable_out, IR_out, PC_out, busy, exception_alignment} !== '0) begin
      miscompares++;
      $display("FAIL sync_reset_outputs: got en=%b addr=%h eo=%b ir=%h pc=%h busy=%b, want all zero",
               mem_read_en, mem_read_addr, enable_out, IR_out, PC_out, busy);
    end
    mem_data = 32'h9999_9999; mem_read_ack = 1; cycle();
    vectors++;
    if (enable_out !== 1'b0 || IR_out !== 32'h0) begin
      miscompares++;
      $display("FAIL sync_reset_late_ack: got eo=%b ir=%h, want 0 00000000", enable_out, IR_out);
    end
    // Asynchronous reset in the middle of an outstanding read.
    start = 1; start_addr = 32'h40; cycle();
    fetch_enable = 1; cycle();
    mem_data = 32'h1; mem_read_ack = 1; cycle();
    fetch_enable = 1; cycle();
    reset_n = 0;
    #2;
    vectors++;
    if ({mem_read_en, mem_read_addr, enable_out, IR_out, PC_out, busy} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got en=%b addr=%h eo=%b ir=%h pc=%h busy=%b, want all zero",
               mem_read_en, mem_read_addr, enable_out, IR_out, PC_out, busy);
    end
    cycle();
    reset_n = 1;
    mem_read_ack = 1; cycle();
    vectors++;
    if (enable_out !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_late_ack: got eo=%b busy=%b, want 0 0", enable_out, busy);
    end
    fetch_enable = 1; cycle();
    vectors++;
    if (mem_read_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset_pc: got addr=%h, want 00000000", mem_read_addr);
    end
    mem_read_ack = 1; cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      fetch_enable = ($urandom_range(0, 99) < 35);
      mem_read_ack = ($urandom_range(0, 99) < 30);
      jump_enable  = ($urandom_range(0, 99) < 8);
      jump_addr    = rand_addr($urandom_range(0, 1) == 0);
      start        = ($urandom_range(0, 99) < 3);
      start_addr   = rand_addr(1'b0);
      sync_reset   = ($urandom_range(0, 199) == 0);
      mem_data     = 32'($urandom());
      cycle();
      vectors++;
      if (mem_read_en !== m_rd || mem_read_addr !== m_addr || busy !== m_outstanding) begin
        miscompares++;
        $display("FAIL rand_request @%0d: got en=%b addr=%h busy=%b, want %b %h %b",
                 i, mem_read_en, mem_read_addr, busy, m_rd, m_addr, m_outstanding);
      end
      if (enable_out !== m_en || IR_out !== m_ir || PC_out !== m_pcout) begin
        miscompares++;
        $display("FAIL rand_deliver @%0d: got eo=%b ir=%h pc=%h, want %b %h %h",
                 i, enable_out, IR_out, PC_out, m_en, m_ir, m_pcout);
      end
      if (exception_alignment !== m_exc) begin
        miscompares++;
        $display("FAIL rand_exception @%0d: got %b, want %b", i, exception_alignment, m_exc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_start_sequence();
    test_jump_fetch();
    test_redirect_in_wait();
    test_misaligned();
    test_wrap_and_resets();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rv2t_instruction_fetch.md
RV2T_INSTRUCTION_FETCH -- requirements
Module: rv2t_instruction_fetch

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- XLEN, 32, instruction/data word width.
- PC_BITWIDTH, 32, byte-address width of PC.
- START_PC, 0, PC value after reset.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sync_reset  in  1  synchronous reset; same effect as reset_n, applied at next clk edge.
- start  in  1  one-cycle pulse; load PC from start_addr.
- start_addr  in  PC_BITWIDTH  boot/restart byte address.
- fetch_enable  in  1  one-cycle pulse from controller; fetch next instruction.
- jump_enable  in  1  one-cycle pulse; redirect PC to jump_addr.
- jump_addr  in  PC_BITWIDTH  redirect byte address.
- mem_read_ack  in  1  one-cycle pulse; mem_data valid.
- mem_data  in  XLEN  instruction word returned by memory.
- mem_read_en  out  1  one-cycle read request pulse.
- mem_read_addr  out  PC_BITWIDTH  byte address of request; held stable until ack.
- enable_out  out  1  one-cycle pulse; IR_out/PC_out hold a new instruction for the decode stage.
- IR_out  out  XLEN  fetched instruction.
- PC_out  out  PC_BITWIDTH  address of IR_out.
- busy  out  1  high while a read is outstanding.
- exception_alignment  out  1  one-cycle pulse; misaligned redirect target rejected.

Function
REQ-003 Two-state FSM, registered state: IDLE, WAIT.
REQ-004 IDLE + fetch_enable at cycle N: mem_read_en=1 and mem_read_addr=PC at cycle N+1; state WAIT from N+1.
REQ-005 WAIT + mem_read_ack at cycle M: IR_out<=mem_data, PC_out<=mem_read_addr, enable_out=1 at M+1 only; PC<=PC+4; state IDLE at M+1.
REQ-006 PC+4 arithmetic is modulo 2^PC_BITWIDTH; 0xFFFFFFFC wraps to 0x00000000.
REQ-007 IR_out/PC_out hold their values between enable_out pulses.
REQ-008 IDLE + jump_enable with jump_addr[1:0]==0: PC<=jump_addr next cycle.
REQ-009 IDLE + jump_enable + fetch_enable in the same cycle: the request is issued at jump_addr (mem_read_addr=jump_addr at N+1); PC then advances from jump_addr.
REQ-010 jump_enable with jump_addr[1:0]!=0: PC unchanged, no fetch issued, exception_alignment=1 for one cycle at the next edge, regardless of state.
REQ-011 WAIT + aligned jump_enable or start: target latched as pending redirect; on the ack, mem_data is discarded (no enable_out), PC<=pending target, state IDLE.
REQ-012 Redirect and ack in the same WAIT cycle: the data is discarded and the redirect applies.
REQ-013 Multiple redirects while in WAIT: the last one wins.
REQ-014 fetch_enable in WAIT is ignored and not queued.
REQ-015 mem_read_ack in IDLE is ignored.
REQ-016 start in IDLE: PC<=start_addr and no fetch issued; start takes priority over jump_enable in the same cycle.
REQ-017 start_addr alignment is not checked; start_addr[1:0] is forced to 0.
REQ-018 busy is 1 exactly while in WAIT.

Reset
REQ-019 reset_n low (asynchronous) or sync_reset high (at the next edge) drives: state IDLE, PC=START_PC, pending redirect cleared, mem_read_en=0, mem_read_addr=0, enable_out=0, IR_out=0, PC_out=0, busy=0, exception_alignment=0.
REQ-020 Reset during WAIT abandons the outstanding read; a late mem_read_ack after reset is ignored under REQ-015.
REQ-021 sync_reset has priority over every other input.

Structure
REQ-022 Shared package: XLEN, PC_BITWIDTH, START_PC default, FSM state encoding.
REQ-023 Single module with no sub-modules; all outputs registered.

Verification
REQ-024 Reset, then fetch_enable at cycle 2 with ack at cycle 5 and mem_data=0x00000013 -> mem_read_en at cycle 3 with addr 0x0; enable_out at cycle 6 with IR_out=0x00000013, PC_out=0x0; PC=0x4.
REQ-025 start with start_addr=0x80 then three fetch/ack pairs -> PC_out sequence 0x80, 0x84, 0x88.
REQ-026 jump_enable and fetch_enable together with jump_addr=0x100 -> mem_read_addr=0x100; after ack, PC_out=0x100 and PC=0x104.
REQ-027 Aligned jump_enable to 0x200 during WAIT, then ack -> no enable_out; PC=0x200; state IDLE.
REQ-028 jump_addr=0x102 -> exception_alignment pulses once; PC unchanged; mem_read_en stays 0.
REQ-029 PC=0xFFFFFFFC, fetch and ack -> PC wraps to 0x0; sync_reset asserted during WAIT -> all outputs 0 next cycle and a later ack produces no enable_out.
